// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment driver with a double-buffered frame
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_PERIOD   = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic [NUM_DIGITS-1:0]         blink_in,
  input  logic                          lz_en,
  input  logic                          load,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_MAX = BW'(BLINK_PERIOD - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] ONE = 1;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz;
  } frame_t;
  localparam frame_t FRAME_RST = '{dig: '0, dp: '0, blank: '1, blink: '0, lz: 1'b0};
  frame_t in_f, sh_q, sh_d, ac_q, ac_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic ph_q, ph_d, pend_q, pend_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, zs;
  logic [3:0] cur;
  logic wrap, swap, sup, z;
  always_comb begin
    in_f = '{dig: digits_in, dp: dp_in, blank: blank_in, blink: blink_in, lz: lz_en};
    wrap = cnt_q == CNT_MAX;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = !wrap ? idx_q : (idx_q == IDX_MAX ? '0 : idx_q + 1'b1);
    bcnt_d = bcnt_q == BL_MAX ? '0 : bcnt_q + 1'b1;
    ph_d = ph_q ^ (bcnt_q == BL_MAX);
    sh_d = load ? in_f : sh_q;
    swap = wrap && idx_q == IDX_MAX && (pend_q || load);
    ac_d = swap ? (load ? in_f : sh_q) : ac_q;
    pend_d = swap ? 1'b0 : (pend_q || load);
    z = 1'b1;
    zs = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && (ac_q.dig[4*i +: 4] == 4'h0);
      zs[i] = z;
    end
    cur = ac_q.dig[4*idx_q +: 4];
    sup = ac_q.blank[idx_q] || (ac_q.blink[idx_q] && ph_q) || (ac_q.lz && zs[idx_q] && idx_q != '0);
    seg_d = sup ? SEG_OFF : (SEG_ACTIVE_LOW ? FONT[cur] : ~FONT[cur]);
    dp_d = (sup || !ac_q.dp[idx_q]) ? DP_OFF : ~DP_OFF;
    an_d = (sup || cnt_q == '0) ? AN_OFF : AN_OFF ^ (ONE << idx_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      ph_q   <= 1'b0;
      pend_q <= 1'b0;
      sh_q   <= FRAME_RST;
      ac_q   <= FRAME_RST;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      an_q   <= AN_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      ph_q   <= ph_d;
      pend_q <= pend_d;
      sh_q   <= sh_d;
      ac_q   <= ac_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end
  assign seg_out  = seg_q;
  assign dp_out   = dp_q;
  assign an_out   = an_q;
  assign scan_idx = idx_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for a 4-digit, 4-clock-slot, 8-clock-blink configuration
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0, blink_in = '0;
  logic lz_en = 1'b0, load = 1'b0;
  logic [6:0] seg_out;
  logic dp_out;
  logic [3:0] an_out;
  logic [1:0] scan_idx;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [6:0] seg; logic dp; logic lit; logic blk;} exp_t;
  exp_t sbq [$];
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_PERIOD(8), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .blink_in(blink_in), .lz_en(lz_en), .load(load), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .scan_idx(scan_idx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                            input logic [3:0] bk, input logic lz, input int first);
    logic z;
    logic [3:0] zs;
    exp_t e;
    z = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      z = z && (d[4*i +: 4] == 4'h0);
      zs[i] = z;
    end
    for (int i = first; i < 4; i++) begin
      e.seg = font[d[4*i +: 4]];
      e.dp = dp[i];
      e.blk = bk[i];
      e.lit = !bl[i] && !(lz && zs[i] && i != 0);
      sbq.push_back(e);
    end
  endtask
  task automatic sb_drain(input int first);
    exp_t e;
    logic ph, lit, edp;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = first; i < 4; i++) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at slot %0d", i);
        return;
      end
      e = sbq.pop_front();
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        ph = (((cyc - 1) / 8) % 2) == 1;
        lit = e.lit && !(e.blk && ph);
        ea = (j == 0 || !lit) ? 4'hF : ~(4'b0001 << i);
        es = lit ? e.seg : 7'h7F;
        edp = lit ? ~e.dp : 1'b1;
        checks++;
        if (an_out !== ea) begin
          errors++;
          $display("FAIL slot%0d.%0d an_out: got %b want %b", i, j, an_out, ea);
        end
        checks++;
        if (dp_out !== edp) begin
          errors++;
          $display("FAIL slot%0d.%0d dp_out: got %b want %b", i, j, dp_out, edp);
        end
        if (j > 0) begin
          checks++;
          if (seg_out !== es) begin
            errors++;
            $display("FAIL slot%0d.%0d seg_out: got %h want %h", i, j, seg_out, es);
          end
        end
        if (j < 3) begin
          checks++;
          if (scan_idx !== 2'(i)) begin
            errors++;
            $display("FAIL slot%0d.%0d scan_idx: got %0d want %0d", i, j, scan_idx, i);
          end
        end
      end
    end
  endtask
  task automatic wait_frame();
    logic [1:0] prev;
    logic hit;
    prev = scan_idx;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      hit = scan_idx == 2'd0 && prev != 2'd0;
      prev = scan_idx;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL frame_wrap timeout: got no wrap want wrap within 200 cycles");
    end
  endtask
  task automatic drive(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                       input logic [3:0] bk, input logic lz);
    digits_in = d;
    dp_in = dp;
    blank_in = bl;
    blink_in = bk;
    lz_en = lz;
    load = 1'b1;
  endtask
  task automatic scramble();
    load = 1'b0;
    digits_in = 16'($urandom);
    dp_in = 4'($urandom);
    blank_in = 4'($urandom);
    blink_in = 4'($urandom);
    lz_en = 1'($urandom);
  endtask
  task automatic load_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                            input logic [3:0] bk, input logic lz);
    drive(d, dp, bl, bk, lz);
    @(negedge clk);
    scramble();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an_out !== 4'hF) begin errors++; $display("FAIL reset an_out: got %b want 1111", an_out); end
    checks++;
    if (seg_out !== 7'h7F) begin errors++; $display("FAIL reset seg_out: got %h want 7f", seg_out); end
    checks++;
    if (dp_out !== 1'b1) begin errors++; $display("FAIL reset dp_out: got %b want 1", dp_out); end
    checks++;
    if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset scan_idx: got %0d want 0", scan_idx); end
    reset = 1'b0;
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 0);
    sb_drain(0);
  endtask
  task automatic test_basic();
    load_frame(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_frame();
    push_frame(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    sb_drain(0);
  endtask
  task automatic test_lz();
    load_frame(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
    wait_frame();
    push_frame(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 0);
    sb_drain(0);
    load_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 0);
    sb_drain(0);
    load_frame(16'h1005, 4'h0, 4'h0, 4'h0, 1'b1);
    wait_frame();
    push_frame(16'h1005, 4'h0, 4'h0, 4'h0, 1'b1, 0);
    sb_drain(0);
  endtask
  task automatic test_load_timing();
    load_frame(16'h4321, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_frame();
    repeat (4) @(negedge clk);
    drive(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    scramble();
    repeat (3) @(negedge clk);
    push_frame(16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 2);
    push_frame(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    sb_drain(2);
    sb_drain(0);
    repeat (15) @(negedge clk);
    drive(16'h5E6F, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    scramble();
    push_frame(16'h5E6F, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    push_frame(16'h5E6F, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    sb_drain(0);
    sb_drain(0);
  endtask
  task automatic test_blink_dp();
    load_frame(16'h3210, 4'b0100, 4'h0, 4'b1010, 1'b0);
    wait_frame();
    push_frame(16'h3210, 4'b0100, 4'h0, 4'b1010, 1'b0, 0);
    push_frame(16'h3210, 4'b0100, 4'h0, 4'b1010, 1'b0, 0);
    sb_drain(0);
    sb_drain(0);
  endtask
  task automatic test_blank();
    load_frame(16'h8888, 4'b0100, 4'b0100, 4'h0, 1'b0);
    wait_frame();
    push_frame(16'h8888, 4'b0100, 4'b0100, 4'h0, 1'b0, 0);
    sb_drain(0);
  endtask
  task automatic test_reset_mid();
    load_frame(16'h0123, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_frame();
    push_frame(16'h0123, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    sb_drain(0);
    repeat (10) @(negedge clk);
    checks++;
    if (an_out !== 4'b1011) begin errors++; $display("FAIL mid an_out before reset: got %b want 1011", an_out); end
    checks++;
    if (seg_out !== 7'h79) begin errors++; $display("FAIL mid seg_out before reset: got %h want 79", seg_out); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (an_out !== 4'hF) begin errors++; $display("FAIL mid reset an_out: got %b want 1111", an_out); end
    checks++;
    if (scan_idx !== 2'd0) begin errors++; $display("FAIL mid reset scan_idx: got %0d want 0", scan_idx); end
    checks++;
    if (seg_out !== 7'h7F) begin errors++; $display("FAIL mid reset seg_out: got %h want 7f", seg_out); end
    reset = 1'b0;
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 0);
    push_frame(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 0);
    sb_drain(0);
    sb_drain(0);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_load_timing();
    test_blink_dp();
    test_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
